// File: rtl/apu_mixer.sv
// N-channel weighted audio mixer: serially accumulates sample*volume over a
// 2^OUTW-clock frame, quantises the sum and drives a PWM or delta-sigma bit.
module apu_mixer #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 4,
    parameter int VOLW     = 4,
    parameter int OUTW     = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] sample,
    input  logic [CHANNELS*VOLW-1:0]  volume,
    input  logic [CHANNELS-1:0]       mute,
    input  logic                      mode,
    output logic                      pwm,
    output logic                      frame,
    output logic [OUTW-1:0]           level
);

    localparam int PW    = WIDTH + VOLW;
    localparam int SUMW  = PW + $clog2(CHANNELS);
    localparam int SHIFT = SUMW - OUTW;
    localparam logic [OUTW-1:0] LEVEL_PHASE = OUTW'(CHANNELS);

    logic [OUTW-1:0]  phase;
    logic [OUTW-1:0]  duty;
    logic [OUTW-1:0]  ds;
    logic             mode_q;
    logic [SUMW-1:0]  acc;

    logic [WIDTH-1:0] cur_sample;
    logic [VOLW-1:0]  cur_volume;
    logic             cur_mute;
    logic [PW-1:0]    product;
    logic [OUTW-1:0]  phase_next;
    logic             boundary;
    logic [OUTW-1:0]  duty_next;
    logic             mode_next;
    logic [OUTW:0]    ds_sum;

    // Only the channel whose slot matches the current phase is looked at.
    always_comb begin
        cur_sample = '0;
        cur_volume = '0;
        cur_mute   = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (phase == OUTW'(k)) begin
                cur_sample = sample[k*WIDTH +: WIDTH];
                cur_volume = volume[k*VOLW +: VOLW];
                cur_mute   = mute[k];
            end
        end
        product = cur_mute ? '0 : PW'(cur_sample) * PW'(cur_volume);
    end

    // Next-state values let pwm be registered yet track the phase it is shown in.
    always_comb begin
        phase_next = phase + OUTW'(1);
        boundary   = (phase == '1);
        duty_next  = boundary ? level : duty;
        mode_next  = boundary ? mode : mode_q;
        ds_sum     = {1'b0, ds} + {1'b0, duty_next};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase  <= '0;
            acc    <= '0;
            level  <= '0;
            duty   <= '0;
            mode_q <= 1'b0;
            ds     <= '0;
            pwm    <= 1'b0;
            frame  <= 1'b0;
        end else begin
            phase <= phase_next;
            if (phase == '0) begin
                acc <= SUMW'(product);
            end else if (phase < LEVEL_PHASE) begin
                acc <= acc + SUMW'(product);
            end
            frame <= (phase == LEVEL_PHASE);
            if (phase == LEVEL_PHASE) begin
                level <= acc[SUMW-1:SHIFT];
            end
            duty   <= duty_next;
            mode_q <= mode_next;
            // The delta-sigma state is held, not cleared, while in PWM mode.
            if (mode_next) begin
                ds  <= ds_sum[OUTW-1:0];
                pwm <= ds_sum[OUTW];
            end else begin
                pwm <= (phase_next < duty_next);
            end
        end
    end

endmodule

// File: doc/apu_mixer.md
# apu_mixer

Parametrised N-channel weighted audio mixer and 1-bit DAC modulator for the APU, successor to the fixed four-channel merged PWM output. It multiplies each channel sample by a per-channel volume, sums them over a time-multiplexed frame and quantises the sum to OUTW bits. The result drives either a frame-aligned PWM or a first-order delta-sigma bitstream. The output feeds the board's external RC low-pass filter.

## Interface
- CHANNELS, 4: number of input channels; must satisfy 1 <= CHANNELS < 2^OUTW - 1.
- WIDTH, 4: per-channel sample width, unsigned.
- VOLW, 4: per-channel volume width, unsigned.
- OUTW, 8: output resolution; frame length is 2^OUTW clocks.
- Derived SUMW = WIDTH + VOLW + clog2(CHANNELS); SHIFT = SUMW - OUTW. SUMW >= OUTW is required.

Ports:
- clk  in  1  system clock, 1.789773 MHz.
- reset_n  in  1  synchronous active-low reset.
- sample  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- volume  in  CHANNELS*VOLW  channel k occupies bits [k*VOLW +: VOLW].
- mute  in  CHANNELS  1 = channel contributes zero.
- mode  in  1  0 = PWM, 1 = delta-sigma.
- pwm  out  1  registered 1-bit audio output.
- frame  out  1  one-cycle pulse when level updates.
- level  out  OUTW  latest quantised mix.

## Operation
- Phase counter: OUTW bits, free-running, wraps from 2^OUTW-1 to 0.
- Accumulation is serial, one channel per clock:
  - At phase 0, acc <= product of channel 0. Acc is cleared, not added.
  - At phase k for 1 <= k < CHANNELS, acc <= acc + product k.
  - Product k = sample_k * volume_k, or 0 if mute[k] is high.
  - Inputs are sampled only in the phase matching their channel. Changes at other phases are ignored until the next frame.
- At phase CHANNELS, level <= acc[SUMW-1:SHIFT] (truncation, no rounding) and frame <= 1. Frame is 0 at all other times.
- Overflow cannot occur, since the maximum sum is below 2^SUMW. No saturation logic is required.
- Frame boundary (edge where phase goes 2^OUTW-1 to 0): duty <= level and mode_q <= mode.
  - Duty and mode_q are constant within a frame.
  - A mode change mid-frame takes effect only at the next boundary.
- PWM mode (mode_q = 0): while phase = p, pwm = (p < duty).
  - Implement as a register loaded from next-state values, so the output is glitch-free.
  - pwm is high for exactly duty clocks per frame, starting at phase 0.
  - duty = 0 gives a constant low output.
- Delta-sigma mode (mode_q = 1): ds is an OUTW-bit register.
  - On each edge, {carry, ds} <= ds + duty_next, where duty_next is the duty value after this edge.
  - pwm <= carry.
  - Gives exactly duty ones per 2^OUTW clocks.
  - ds is not cleared at a mode switch; it resumes from its held value.
- Reset (reset_n low at an edge) zeroes every register: phase, acc, level, duty, mode_q, ds, pwm, frame.
  - This also applies mid-frame. A partial frame is discarded.
  - The first frame restarts at phase 0 on the first edge after release.

## Timing
- Reset values: pwm = 0, frame = 0, level = 0.
- Latency from sampling channel 0 to level valid: CHANNELS+1 edges.
- frame and the new level are visible together during phase CHANNELS+1.
- Latency from level update to pwm duty: up to the next frame boundary. Worst case is 2^OUTW - CHANNELS - 1 clocks.
- With defaults (OUTW = 8), the frame is 256 clocks, about 6.99 kHz, above the 4 kHz filter corner.

## Test plan
All cases use the defaults: SUMW = 10, SHIFT = 2.
- Reset: hold reset_n low 3 cycles with all inputs at maximum -> pwm = 0, frame = 0, level = 0. After release, frame pulses during phase 5, then every 256 clocks.
- Single channel: ch0 = 15, vol0 = 15, others 0, mode 0 -> level = 56. The next frame has pwm high for phases 0-55 and low for phases 56-255.
- Full scale: all samples and volumes = 15 -> sum 900, level = 225, 225 high clocks per frame. Then set mute = 4'b1111 -> level = 0 and pwm stays low for the entire following frame.
- Delta-sigma: mode 1 with products ch0 = 15*15, ch1 = 15*15, ch2 = 15*4, ch3 = 1*2 -> sum 512, level 128. The following frame alternates pwm 0,1,0,1 and has exactly 128 ones.
- Mid-frame stability: in steady state with level 56, change sample0 to 0 at phase 100 -> pwm still high for 56 clocks in the current frame and level unchanged. At the next phase 5, level = 0, then duty = 0 from the next boundary.
- Mid-frame reset: assert reset_n low at phase 30 in PWM mode with duty 56 -> pwm = 0 on the next edge. After release, level = 0 until the first frame pulse and no residual high output appears.
